// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - fabric-side request/grant/read-return and conf bundle for sram_port_arbiter
interface sram_port_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [9:0]  addr0;
    logic [9:0]  addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        cfg_req;
    logic [1:0]  cfg_conf;
    logic        cfg_ack;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, cfg_req, cfg_conf,
        input  gnt, rvalid, rdata, cfg_ack
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, cfg_req, cfg_conf,
        output gnt, rvalid, rdata, cfg_ack
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-master write/read slot arbiter, read tagger and conf sequencer for sram_ifc_8_32
module sram_port_arbiter #(
    parameter int OUT_REG = 0,
    parameter int RD_LAT  = 3 + OUT_REG
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_port_arbiter_if.slave   fab,
    output logic                 csb,
    output logic                 web,
    output logic                 reb,
    output logic [9:0]           addr_w,
    output logic [9:0]           addr_r,
    output logic [31:0]          d_fabric_in,
    output logic [1:0]           conf,
    output logic                 out_reg,
    input  logic [31:0]          d_fabric_out
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               wptr;
    logic               rptr;
    logic               grant_en;
    logic [1:0]         wcand;
    logic [1:0]         rcand;
    logic               wgnt;
    logic               rgnt;
    logic               wwin;
    logic               rwin;
    logic [1:0]         gnt;
    logic [1:0]         rvalid;
    logic               cfg_ack;
    logic               drain_done;
    logic [RD_LAT-1:0]  tag_vld;
    logic [RD_LAT-1:0]  tag_id;

    // Grants are also gated by rst_n so they read 0 throughout an asynchronous reset.
    always_comb begin
        grant_en = rst_n && (state == RUN) && !fab.cfg_req;
        wcand    = fab.req & fab.we  & {2{grant_en}};
        rcand    = fab.req & ~fab.we & {2{grant_en}};
        wgnt     = |wcand;
        rgnt     = |rcand;
        wwin     = (wcand == 2'b11) ? wptr : wcand[1];
        rwin     = (rcand == 2'b11) ? rptr : rcand[1];
        gnt      = {wgnt & wwin, wgnt & ~wwin} | {rgnt & rwin, rgnt & ~rwin};
    end

    always_comb begin
        web         = ~wgnt;
        reb         = ~rgnt;
        csb         = ~(wgnt | rgnt);
        addr_w      = '0;
        d_fabric_in = '0;
        addr_r      = '0;
        if (wgnt) begin
            addr_w      = wwin ? fab.addr1  : fab.addr0;
            d_fabric_in = wwin ? fab.wdata1 : fab.wdata0;
        end
        if (rgnt) begin
            addr_r = rwin ? fab.addr1 : fab.addr0;
        end
    end

    always_comb begin
        rvalid = {tag_vld[RD_LAT-1] & tag_id[RD_LAT-1],
                  tag_vld[RD_LAT-1] & ~tag_id[RD_LAT-1]};
    end

    // The pipe is drained once nothing will remain after this cycle's shift, so the
    // ack lands in the cycle right after the final rvalid.
    always_comb begin
        drain_done = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            if (tag_vld[i]) begin
                drain_done = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ack   = 1'b0;
        case (state)
            RUN: begin
                if (fab.cfg_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                cfg_ack   = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            conf    <= 2'b00;
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            state <= state_nxt;
            if (wgnt) begin
                wptr <= ~wwin;
            end
            if (rgnt) begin
                rptr <= ~rwin;
            end
            if (state == UPDATE) begin
                conf <= fab.cfg_conf;
            end
            tag_vld[0] <= rgnt;
            tag_id[0]  <= rwin;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign fab.gnt     = gnt;
    assign fab.rvalid  = rvalid;
    assign fab.rdata   = d_fabric_out;
    assign fab.cfg_ack = cfg_ack;
    assign out_reg     = 1'(OUT_REG);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter with a behavioural SRAM macro
module tb_sram_port_arbiter;
    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csb, web, reb, out_reg;
    logic [9:0]  addr_w, addr_r;
    logic [31:0] d_fabric_in, d_fabric_out;
    logic [1:0]  conf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit push_en = 1'b1;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     sb[$];
    logic [31:0] shadow [0:1023];
    logic [31:0] mem    [0:1023];
    logic [31:0] dpipe  [0:RD_LAT-1];

    sram_port_arbiter_if fab();

    sram_port_arbiter #(.OUT_REG(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fab          (fab),
        .csb          (csb),
        .web          (web),
        .reb          (reb),
        .addr_w       (addr_w),
        .addr_r       (addr_r),
        .d_fabric_in  (d_fabric_in),
        .conf         (conf),
        .out_reg      (out_reg),
        .d_fabric_out (d_fabric_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: write on the edge, read data appears RD_LAT cycles after issue.
    always @(posedge clk) begin
        if (!csb && !web) mem[addr_w] <= d_fabric_in;
        dpipe[0] <= (!csb && !reb) ? mem[addr_r] : 32'h0;
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign d_fabric_out = dpipe[RD_LAT-1];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            rd_exp_t e;
            e = sb.pop_front();
            check("rvalid", fab.rvalid, e.id ? 2'b10 : 2'b01);
            check("rdata", fab.rdata, e.data);
        end else begin
            check("rvalid_idle", fab.rvalid, 2'b00);
        end
    end

    task automatic step(input logic [1:0] r, input logic [1:0] w,
                        input logic [9:0] a0, input logic [9:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic creq, input logic [1:0] cconf,
                        input logic [1:0] eg, input logic eack);
        logic [1:0] ew;
        logic [1:0] er;
        rd_exp_t    e;
        fab.req = r; fab.we = w; fab.addr0 = a0; fab.addr1 = a1;
        fab.wdata0 = d0; fab.wdata1 = d1; fab.cfg_req = creq; fab.cfg_conf = cconf;
        ew = eg & r & w;
        er = eg & r & ~w;
        @(negedge clk);
        check("gnt", fab.gnt, eg);
        check("cfg_ack", fab.cfg_ack, eack);
        check("web", web, ~|ew);
        check("reb", reb, ~|er);
        check("csb", csb, ~|(ew | er));
        check("addr_w", addr_w, ew[1] ? a1 : (ew[0] ? a0 : 10'h0));
        check("d_fabric_in", d_fabric_in, ew[1] ? d1 : (ew[0] ? d0 : 32'h0));
        check("addr_r", addr_r, er[1] ? a1 : (er[0] ? a0 : 10'h0));
        for (int i = 0; i < 2; i++) begin
            if (er[i] && push_en) begin
                e.id   = 1'(i);
                e.data = shadow[(i == 1) ? a1 : a0];
                e.due  = cyc + RD_LAT;
                sb.push_back(e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (ew[i]) shadow[(i == 1) ? a1 : a0] = (i == 1) ? d1 : d0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_gnt", fab.gnt, 2'b00);
        check("rst_rvalid", fab.rvalid, 2'b00);
        check("rst_cfg_ack", fab.cfg_ack, 1'b0);
        check("rst_csb", csb, 1'b1);
        check("rst_web", web, 1'b1);
        check("rst_reb", reb, 1'b1);
        check("rst_addr_w", addr_w, 10'h0);
        check("rst_addr_r", addr_r, 10'h0);
        check("rst_d_in", d_fabric_in, 32'h0);
        check("rst_conf", conf, 2'b00);
    endtask

    initial begin
        fab.req = 2'b11; fab.we = 2'b00; fab.addr0 = 10'h0; fab.addr1 = 10'h0;
        fab.wdata0 = 32'h0; fab.wdata1 = 32'h0; fab.cfg_req = 1'b0; fab.cfg_conf = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        check("out_reg", out_reg, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single write then read by master 0, then master 1 reads the same word
        step(2'b01, 2'b01, 10'h005, 10'h0, 32'hDEADBEEF, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0);
        step(2'b01, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0);
        step(2'b10, 2'b00, 10'h0, 10'h005, 32'h0, 32'h0, 1'b0, 2'b00, 2'b10, 1'b0);

        // write contention: wptr points at master 1 after master 0's earlier write
        step(2'b11, 2'b11, 10'h010, 10'h011, 32'h11110000, 32'h22220000, 1'b0, 2'b00, 2'b10, 1'b0);
        step(2'b11, 2'b11, 10'h010, 10'h011, 32'h11110000, 32'h22220000, 1'b0, 2'b00, 2'b01, 1'b0);

        // read contention for 4 cycles
        for (int k = 0; k < 4; k++)
            step(2'b11, 2'b00, 10'h010, 10'h011, 32'h0, 32'h0, 1'b0, 2'b00, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0);

        // mixed slots: master 0 writes while master 1 reads
        step(2'b11, 2'b01, 10'h3FF, 10'h011, 32'hCAFEF00D, 32'h0, 1'b0, 2'b00, 2'b11, 1'b0);
        idle(4);

        // idle conf change; cfg_conf only matters in the UPDATE cycle
        step(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 1'b1, 2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 1'b1, 2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 1'b1, 2'b01, 2'b00, 1'b1);
        check("conf_idle", conf, 2'b01);
        idle(1);

        // conf change with two reads in flight
        step(2'b01, 2'b00, 10'h3FF, 10'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0);
        step(2'b10, 2'b00, 10'h0, 10'h005, 32'h0, 32'h0, 1'b0, 2'b00, 2'b10, 1'b0);
        for (int k = 0; k < 4; k++)
            step(2'b11, 2'b00, 10'h010, 10'h011, 32'h0, 32'h0, 1'b1, 2'b10, 2'b00, (k == 3) ? 1'b1 : 1'b0);
        check("conf_stream", conf, 2'b10);
        step(2'b11, 2'b00, 10'h010, 10'h011, 32'h0, 32'h0, 1'b0, 2'b10, 2'b01, 1'b0);
        idle(4);

        // reset one cycle after a read grant: that read must never return
        push_en = 1'b0;
        step(2'b01, 2'b00, 10'h010, 10'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0);
        push_en = 1'b1;
        fab.req = 2'b11; fab.we = 2'b00; fab.addr0 = 10'h010; fab.addr1 = 10'h011;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2'b11, 2'b00, 10'h010, 10'h011, 32'h0, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0);
        idle(6);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
